fnd_display_controller: RTL and testbench

Consumes the free-running 14-bit 0–9999 count from the upstream counter stage and drives a 4-digit, common-anode, active-low 7-segment display. A sequential double-dabble engine converts the binary value to four BCD digits. A prescaled scan sequencer then time-multiplexes the digits onto the shared segment bus, with leading-zero blanking.

---
 rtl/fnd_display_controller.sv | 133 +++++++++++++
 tb/tb_fnd_display_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fnd_display_controller.sv
// Binary-to-BCD conversion by sequential double dabble, feeding a
// time-multiplexed 4-digit active-low 7-segment driver with leading-zero blanking.
module fnd_display_controller #(
  parameter int unsigned SCAN_DIV      = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [13:0] i_value,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_font,
  output logic [15:0] o_bcd,
  output logic        o_bcd_valid
);

  localparam int unsigned VAL_W = 14;
  localparam int unsigned BCD_W = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PRE_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [VAL_W-1:0] VAL_MAX  = VAL_W'(9999);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [VAL_W-1:0]  bin_q;
  logic [BCD_W-1:0]  acc_q, acc_adj;
  logic [PRE_W-1:0]  pre_q;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        digit;
  logic              blank;
  logic [7:0]        font_d;
  logic [3:0]        com_d;

  // Conversion FSM: state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Conversion FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every BCD nibble that would overflow past 9 after the shift
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_cnt_q   <= '0;
      bin_q       <= '0;
      acc_q       <= '0;
      o_bcd       <= '0;
      o_bcd_valid <= 1'b0;
    end else begin
      o_bcd_valid <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          bin_q     <= (i_value > VAL_MAX) ? VAL_MAX : i_value;
          acc_q     <= '0;
          bit_cnt_q <= CNT_W'(VAL_W - 1);
        end
        SHIFT: begin
          {acc_q, bin_q} <= {acc_adj[BCD_W-2:0], bin_q, 1'b0};
          bit_cnt_q      <= bit_cnt_q - CNT_W'(1);
        end
        DONE:    o_bcd <= acc_q;
        default: ;
      endcase
    end
  end

  // Scan sequencer: digit index and its decoded font, registered together
  always_comb begin
    idx_d = idx_q;
    if (pre_q == PRE_LAST) idx_d = idx_q + 2'd1;

    digit = o_bcd[3:0];
    blank = 1'b0;
    case (idx_d)
      2'd0: digit = o_bcd[3:0];
      2'd1: begin digit = o_bcd[7:4];   blank = (o_bcd[15:4]  == '0); end
      2'd2: begin digit = o_bcd[11:8];  blank = (o_bcd[15:8]  == '0); end
      2'd3: begin digit = o_bcd[15:12]; blank = (o_bcd[15:12] == '0); end
      default: ;
    endcase

    case (digit)
      4'd0:    font_d = 8'hC0;
      4'd1:    font_d = 8'hF9;
      4'd2:    font_d = 8'hA4;
      4'd3:    font_d = 8'hB0;
      4'd4:    font_d = 8'h99;
      4'd5:    font_d = 8'h92;
      4'd6:    font_d = 8'h82;
      4'd7:    font_d = 8'hF8;
      4'd8:    font_d = 8'h80;
      4'd9:    font_d = 8'h90;
      default: font_d = 8'hFF;
    endcase
    if (blank && BLANK_LEADING) font_d = 8'hFF;

    com_d = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_q      <= '0;
      idx_q      <= '0;
      o_fnd_com  <= 4'b1110;
      o_fnd_font <= 8'hC0;
    end else begin
      pre_q      <= (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
      idx_q      <= idx_d;
      o_fnd_com  <= com_d;
      o_fnd_font <= font_d;
    end
  end

endmodule

// File: tb/tb_fnd_display_controller.sv
// Self-checking bench: random and directed values compared against a decimal-arithmetic model.
module tb_fnd_display_controller;

  localparam int unsigned SD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] value;
  logic [3:0]  com_b, com_n;
  logic [7:0]  font_b, font_n;
  logic [15:0] bcd_b, bcd_n;
  logic        valid_b, valid_n;

  int n_cmp = 0;
  int n_fail = 0;
  int unsigned ecnt;

  fnd_display_controller #(.SCAN_DIV(SD), .BLANK_LEADING(1'b1)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_value(value),
    .o_fnd_com(com_b), .o_fnd_font(font_b), .o_bcd(bcd_b), .o_bcd_valid(valid_b));

  fnd_display_controller #(.SCAN_DIV(SD), .BLANK_LEADING(1'b0)) dut_nb (
    .i_clk(clk), .i_reset_n(rst_n), .i_value(value),
    .o_fnd_com(com_n), .o_fnd_font(font_n), .o_bcd(bcd_n), .o_bcd_valid(valid_n));

  always #5 clk = ~clk;

  // Rising edges since the last reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  function automatic logic [15:0] ref_bcd(input int unsigned v);
    int unsigned c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [7:0] ref_font(input int unsigned v, input int unsigned pos, input bit blank_en);
    int unsigned c, p10, d;
    logic [7:0] f;
    c   = (v > 9999) ? 9999 : v;
    p10 = (pos == 0) ? 1 : (pos == 1) ? 10 : (pos == 2) ? 100 : 1000;
    d   = (c / p10) % 10;
    case (d)
      0: f = 8'hC0; 1: f = 8'hF9; 2: f = 8'hA4; 3: f = 8'hB0; 4: f = 8'h99;
      5: f = 8'h92; 6: f = 8'h82; 7: f = 8'hF8; 8: f = 8'h80; default: f = 8'h90;
    endcase
    if (blank_en && pos > 0 && c < p10) f = 8'hFF;
    return f;
  endfunction

  // Move to the falling edge just before a capture edge
  task automatic align();
    @(negedge clk);
    for (int i = 0; i < 16 && (ecnt % 16) != 0; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    bit found;
    rst_n = 1'b0;
    value = 14'd1234;
    repeat (2) @(negedge clk);
    n_cmp += 4;
    if (com_b !== 4'b1110) begin n_fail++; $display("FAIL reset_com: got %b want 1110", com_b); end
    if (font_b !== 8'hC0) begin n_fail++; $display("FAIL reset_font: got %h want c0", font_b); end
    if (bcd_b !== 16'h0000) begin n_fail++; $display("FAIL reset_bcd: got %h want 0000", bcd_b); end
    if (valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_b); end
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (valid_b === 1'b1) found = 1'b1;
    end
    n_cmp += 3;
    if (!found || ecnt != 16) begin n_fail++; $display("FAIL first_valid_edge: got %0d want 16", ecnt); end
    if (bcd_b !== 16'h1234) begin n_fail++; $display("FAIL first_bcd: got %h want 1234", bcd_b); end
    @(negedge clk);
    if (valid_b !== 1'b0) begin n_fail++; $display("FAIL valid_pulse_width: got %b want 0", valid_b); end
  endtask

  task automatic test_sweep();
    int unsigned vals[8] = '{0, 9, 10, 99, 100, 5555, 9999, 16383};
    int unsigned v;
    int early;
    for (int k = 0; k < 20; k++) begin
      v = (k < 8) ? vals[k] : $urandom_range(0, 16383);
      align();
      value = 14'(v);
      early = 0;
      repeat (15) begin
        @(negedge clk);
        if (valid_b !== 1'b0) early++;
      end
      @(negedge clk);
      n_cmp += 3;
      if (early != 0 || valid_b !== 1'b1) begin
        n_fail++; $display("FAIL sweep_valid_timing v=%0d: early=%0d valid=%b want early=0 valid=1", v, early, valid_b);
      end
      if (bcd_b !== ref_bcd(v)) begin n_fail++; $display("FAIL sweep_bcd v=%0d: got %h want %h", v, bcd_b, ref_bcd(v)); end
      if (bcd_n !== ref_bcd(v)) begin n_fail++; $display("FAIL sweep_bcd_nb v=%0d: got %h want %h", v, bcd_n, ref_bcd(v)); end
    end
  endtask

  task automatic test_capture_isolation();
    align();
    value = 14'd1234;
    repeat (4) @(negedge clk);
    value = 14'd4321;
    repeat (12) @(negedge clk);
    n_cmp += 2;
    if (valid_b !== 1'b1 || bcd_b !== 16'h1234) begin
      n_fail++; $display("FAIL isolation_first: got %h valid=%b want 1234 valid=1", bcd_b, valid_b);
    end
    repeat (16) @(negedge clk);
    if (valid_b !== 1'b1 || bcd_b !== 16'h4321) begin
      n_fail++; $display("FAIL isolation_second: got %h valid=%b want 4321 valid=1", bcd_b, valid_b);
    end
  endtask

  task automatic test_scan();
    logic [7:0] lit [4] = '{8'h92, 8'h82, 8'hF8, 8'h80};
    int unsigned idx;
    logic [3:0] exp_com;
    align();
    value = 14'd8765;
    repeat (17) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      idx = (ecnt / SD) % 4;
      exp_com = 4'(~(4'b0001 << idx));
      n_cmp += 3;
      if (com_b !== exp_com) begin n_fail++; $display("FAIL scan_com t=%0d: got %b want %b", ecnt, com_b, exp_com); end
      if (font_b !== lit[idx]) begin n_fail++; $display("FAIL scan_font t=%0d: got %h want %h", ecnt, font_b, lit[idx]); end
      if (com_n !== exp_com) begin n_fail++; $display("FAIL scan_com_nb t=%0d: got %b want %b", ecnt, com_n, exp_com); end
    end
  endtask

  task automatic test_blanking();
    int unsigned vals[6];
    int unsigned v, idx;
    vals = '{7, 0, 1005, 2349, $urandom_range(0, 999), $urandom_range(0, 16383)};
    for (int k = 0; k < 6; k++) begin
      v = vals[k];
      align();
      value = 14'(v);
      repeat (17) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        idx = (ecnt / SD) % 4;
        n_cmp += 2;
        if (font_b !== ref_font(v, idx, 1'b1)) begin
          n_fail++; $display("FAIL blank_font v=%0d pos=%0d: got %h want %h", v, idx, font_b, ref_font(v, idx, 1'b1));
        end
        if (font_n !== ref_font(v, idx, 1'b0)) begin
          n_fail++; $display("FAIL noblank_font v=%0d pos=%0d: got %h want %h", v, idx, font_n, ref_font(v, idx, 1'b0));
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    align();
    value = 14'd4321;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (com_b !== 4'b1110) begin n_fail++; $display("FAIL midrst_com: got %b want 1110", com_b); end
    if (font_b !== 8'hC0) begin n_fail++; $display("FAIL midrst_font: got %h want c0", font_b); end
    if (bcd_b !== 16'h0000) begin n_fail++; $display("FAIL midrst_bcd: got %h want 0000", bcd_b); end
    if (valid_b !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", valid_b); end
    value = 14'd987;
    @(negedge clk);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (valid_b === 1'b1) found = 1'b1;
    end
    n_cmp += 2;
    if (!found || ecnt != 16) begin n_fail++; $display("FAIL midrst_valid_edge: got %0d want 16", ecnt); end
    if (bcd_b !== ref_bcd(987)) begin n_fail++; $display("FAIL midrst_bcd_after: got %h want %h", bcd_b, ref_bcd(987)); end
  endtask

  initial begin
    rst_n = 1'b0;
    value = '0;
    test_reset();
    test_sweep();
    test_capture_isolation();
    test_scan();
    test_blanking();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
